fetch_sequencer: RTL

Instruction-fetch controller for the single-issue RV32I core. It owns the program counter, issues one request at a time to instruction memory, and latches each returned word into an IF/ID holding register. It presents that word to the decode stage through a valid/ready handshake and handles control-flow redirects, including discarding any fetch still in flight. It also flags unsupported opcodes and misaligned redirect targets.

---
 rtl/rv_pkg.sv | 27 ++
 rtl/opcode_check.sv | 18 +
 rtl/fetch_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: base opcodes, fetch FSM states, canonical NOP.
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN,
    ST_FAULT
  } fetch_state_t;

endpackage

// File: rtl/opcode_check.sv
// Combinational RV32I base-opcode legality check; shared by fetch and decode.
module opcode_check
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       legal_o
);

  always_comb begin
    legal_o = 1'b0;
    case (opcode_i)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: legal_o = 1'b1;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch with an IF/ID holding register and redirect handling.
// Outputs are decoded purely from registered state; a redirect never reaches an output combinationally.
module fetch_sequencer
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_insn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_insn,
  output logic [31:0] id_pc,
  output logic        id_illegal,
  output logic        fetch_fault,
  output logic [31:0] insn_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  insn_q, insn_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         ill_q, ill_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         op_legal;
  logic         redir_act;

  opcode_check u_opcode_check (
    .opcode_i (imem_insn[6:0]),
    .legal_o  (op_legal)
  );

  assign redir_act = redirect_valid && (state_q != ST_FAULT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
    ipc_d   = ipc_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;

    // A handshake completes whenever the word is held and decode takes it, redirect or not.
    if (state_q == ST_HOLD && id_ready) begin
      cnt_d = cnt_q + 32'd1;
    end

    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid && !redirect_valid) begin
          insn_d  = imem_insn;
          ipc_d   = pc_q;
          ill_d   = !op_legal;
          pc_d    = pc_q + 32'd4;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD:  if (id_ready) state_d = ST_FETCH;
      ST_DRAIN: if (imem_rvalid) state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    if (redir_act) begin
      if (redirect_pc[1:0] != 2'b00) begin
        pc_d    = pc_q;
        state_d = ST_FAULT;
      end else begin
        pc_d = redirect_pc;
        // Any request whose response is still outstanding must be swallowed in DRAIN.
        case (state_q)
          ST_FETCH:          state_d = ST_DRAIN;
          ST_WAIT, ST_DRAIN: state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
          default:           state_d = ST_FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      insn_q  <= NOP_INSN;
      ipc_q   <= 32'h0;
      ill_q   <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      ipc_q   <= ipc_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = (state_q == ST_FETCH) ? pc_q : 32'h0;
  assign id_valid    = (state_q == ST_HOLD);
  assign id_insn     = insn_q;
  assign id_pc       = ipc_q;
  assign id_illegal  = ill_q;
  assign fetch_fault = (state_q == ST_FAULT);
  assign insn_count  = cnt_q;

endmodule
